// File: rtl/ipb_pkg.sv
// Shared definitions for the instruction prefetch buffer.
//
// Contents:
//   ipb_state_e - fetch state: RUN issues requests, HALT stops after the
//                 end-of-program word has been buffered
//   EOP_WORD    - instruction encoding that marks the end of the program
//   PC_STEP     - byte distance between sequential instruction words
//   cnt_width() - width of a counter that must hold 0..depth inclusive
package ipb_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } ipb_state_e;

    localparam logic [31:0] EOP_WORD = 32'hFFFF_FFFF;
    localparam int          PC_STEP  = 4;

    // One extra bit over the index width so "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding {instruction, pc} entries for the prefetch buffer.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   push      in   write push_data at the tail (ignored when full)
//   pop       in   drop the head entry (ignored when empty)
//   clear     in   empty the FIFO; wins over push and pop in the same cycle
//   push_data in   WIDTH-bit entry to write
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   count     out  number of entries held
//   head      out  oldest entry, read straight from the storage registers
module instr_fifo
    import ipb_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               push_data,
    output logic                           full,
    output logic                           empty,
    output logic [cnt_width(DEPTH)-1:0]    count,
    output logic [WIDTH-1:0]               head
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer sitting between the instruction memory port and
// the fetch/decode register. Issues sequential word fetches, buffers returned
// words with their PC, handles stalls, branch redirects and end-of-program halt.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   req_valid/addr/ready    fetch request channel (valid/ready)
//   resp_valid/resp_data    in-order response channel
//   redirect/redirect_pc    branch redirect: flush and refetch from redirect_pc
//   instr_ready             core accepts the head entry
//   instr_valid/instr/pc    head entry presented to the core
//   halted                  end-of-program word buffered, no further requests
//
// Build option: define IPB_BYPASS_EN to forward a response straight to the
// core when the FIFO is empty and the core is ready (zero-cycle fill latency).
module instr_prefetch_buffer
    import ipb_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               req_valid,
    output logic [ADDR_W-1:0]  req_addr,
    input  logic               req_ready,
    input  logic               resp_valid,
    input  logic [INSTR_W-1:0] resp_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted
);

    localparam int                CW      = cnt_width(DEPTH);
    localparam int                EW      = INSTR_W + ADDR_W;
    localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

    ipb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q, discard_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     fifo_head;
    logic [CW:0]       occupancy;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              req_fire, resp_fire, resp_keep, bypass, head_valid;

    instr_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (redirect),
        .push_data ({resp_data, resp_pc_q}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Credit rule: queued plus in-flight words never exceed the FIFO depth,
    // so every response is guaranteed a free slot.
    assign occupancy        = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_valid        = reset && (state_q == RUN) && (occupancy < DEPTH_C);
    assign req_addr         = fetch_pc_q;
    assign req_fire         = req_valid && req_ready;
    assign redirect_aligned = redirect_pc & ~(ADDR_W'(3));

    // A response with nothing outstanding belongs to a request issued before
    // reset and is ignored. Responses arriving with a redirect are dropped.
    assign resp_fire = reset && resp_valid && (outstanding_q != '0);
    assign resp_keep = resp_fire && (discard_q == '0) && !redirect;

`ifdef IPB_BYPASS_EN
    assign bypass = resp_keep && fifo_empty && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push   = resp_keep && !bypass;
    assign head_valid  = reset && !fifo_empty;
    assign fifo_pop    = head_valid && instr_ready;
    assign instr_valid = head_valid || bypass;
    assign halted      = reset && (state_q == HALT);

    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (head_valid) begin
            instr    = fifo_head[EW-1:ADDR_W];
            instr_pc = fifo_head[ADDR_W-1:0];
        end else if (bypass) begin
            instr    = resp_data;
            instr_pc = resp_pc_q;
        end
    end

    // Next-state for the FSM, PCs and credit counters. A redirect overrides
    // everything else: words still in flight (including one accepted in this
    // very cycle) are counted into discard so they are thrown away on arrival.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);

        if (redirect) begin
            state_d    = RUN;
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (resp_fire && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + STEP;
                if (resp_data == INSTR_W'(EOP_WORD)) begin
                    state_d = HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Overflow can only come from a broken credit rule.
    always_ff @(posedge clk) begin
        if (reset && fifo_push && !redirect) begin
            assert (!fifo_full);
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int ready_mode = 0;
    logic [63:0] eop_addr = '1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          cyc;
    } rx_t;
    rx_t         rx[$];
    logic [63:0] reqlog[$];
    int          reqcyc[$];

    instr_prefetch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == eop_addr) return 32'hFFFF_FFFF;
        return 32'h1000_0000 | a[31:0];
    endfunction

    // Memory model: decides responses and req_ready for the upcoming edge.
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            resp_valid = 1'b0;
            resp_data  = '0;
            if (!reset) begin
                pend.delete();
                req_ready = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_word(pend[0].addr);
                    pend.delete(0);
                end
                case (ready_mode)
                    0:       req_ready = 1'b0;
                    1:       req_ready = 1'b1;
                    default: req_ready = ($urandom_range(0, 1) == 1);
                endcase
                if (req_valid && req_ready) begin
                    pend.push_back('{req_addr, cyc + 1 + lat});
                end
            end
        end
    end

    // Observer: logs accepted requests and consumed instructions.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                if (req_valid && req_ready) begin
                    reqlog.push_back(req_addr);
                    reqcyc.push_back(cyc + 1);
                end
                if (instr_valid && instr_ready && !redirect) begin
                    rx.push_back('{instr_pc, instr, cyc + 1});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic hold_reset();
        @(negedge clk);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        ready_mode  = 0;
        eop_addr    = '1;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        reqlog.delete();
        reqcyc.delete();
        rx.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        hold_reset();
        #3;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_valid actual=%0b expected=0", req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_instr_valid actual=%0b expected=0", instr_valid);
        end
        checks++;
        if (instr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_instr actual=%h expected=0", instr);
        end
        checks++;
        if (instr_pc !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_instr_pc actual=%h expected=0", instr_pc);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_halted actual=%0b expected=0", halted);
        end
        release_reset();
        #3;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_first_req actual=%0b/%h expected=1/0", req_valid, req_addr);
        end
    endtask

    task automatic test_sequential();
        int exp_cyc;
        hold_reset();
        lat = 1;
        ready_mode = 1;
        instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 40 && rx.size() < 3; i++) @(negedge clk);
        checks++;
        if (rx.size() < 3) begin
            errors++;
            $display("[TB] FAIL seq_timeout actual=%0d words expected=3", rx.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (reqlog[i] !== 64'(i * 4)) begin
                    errors++;
                    $display("[TB] FAIL seq_req_addr[%0d] actual=%h expected=%h", i, reqlog[i], 64'(i * 4));
                end
                checks++;
                if (rx[i].pc !== 64'(i * 4) || rx[i].data !== (32'h1000_0000 | 32'(i * 4))) begin
                    errors++;
                    $display("[TB] FAIL seq_instr[%0d] actual=%h/%h expected=%h/%h", i, rx[i].pc, rx[i].data,
                             64'(i * 4), 32'h1000_0000 | 32'(i * 4));
                end
            end
            checks++;
            if (reqcyc[1] !== reqcyc[0] + 1 || reqcyc[2] !== reqcyc[1] + 1) begin
                errors++;
                $display("[TB] FAIL seq_back_to_back actual=%0d,%0d,%0d expected consecutive", reqcyc[0], reqcyc[1], reqcyc[2]);
            end
`ifdef IPB_BYPASS_EN
            exp_cyc = reqcyc[0] + 1;
`else
            exp_cyc = reqcyc[0] + 2;
`endif
            checks++;
            if (rx[0].cyc !== exp_cyc) begin
                errors++;
                $display("[TB] FAIL seq_fill_latency actual=%0d expected=%0d", rx[0].cyc, exp_cyc);
            end
        end
    endtask

    task automatic test_stall();
        hold_reset();
        lat = 1;
        ready_mode = 1;
        instr_ready = 1'b0;
        release_reset();
        repeat (10) @(negedge clk);
        #3;
        checks++;
        if (reqlog.size() !== 4) begin
            errors++;
            $display("[TB] FAIL stall_req_count actual=%0d expected=4", reqlog.size());
        end
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_req_valid actual=%0b expected=0", req_valid);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h0 || instr !== 32'h1000_0000) begin
            errors++;
            $display("[TB] FAIL stall_head actual=%0b/%h/%h expected=1/0/10000000", instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && rx.size() < 8; i++) @(negedge clk);
        checks++;
        if (rx.size() < 8) begin
            errors++;
            $display("[TB] FAIL stall_timeout actual=%0d words expected=8", rx.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rx[i].pc !== 64'(i * 4) || rx[i].data !== (32'h1000_0000 | 32'(i * 4))) begin
                    errors++;
                    $display("[TB] FAIL stall_drain[%0d] actual=%h/%h expected=%h/%h", i, rx[i].pc, rx[i].data,
                             64'(i * 4), 32'h1000_0000 | 32'(i * 4));
                end
            end
        end
    endtask

    task automatic test_redirect();
        hold_reset();
        lat = 3;
        ready_mode = 1;
        instr_ready = 1'b1;
        release_reset();
        for (int i = 0; i < 20 && reqlog.size() < 2; i++) @(negedge clk);
        ready_mode  = 0;
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        checks++;
        if (reqlog.size() !== 2 || rx.size() !== 0) begin
            errors++;
            $display("[TB] FAIL redir_setup actual=%0d req/%0d rx expected=2/0", reqlog.size(), rx.size());
        end
        @(negedge clk);
        redirect   = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 40 && rx.size() < 2; i++) @(negedge clk);
        checks++;
        if (rx.size() < 2) begin
            errors++;
            $display("[TB] FAIL redir_timeout actual=%0d words expected=2", rx.size());
        end else begin
            checks++;
            if (rx[0].pc !== 64'h100 || rx[0].data !== 32'h1000_0100) begin
                errors++;
                $display("[TB] FAIL redir_first actual=%h/%h expected=100/10000100", rx[0].pc, rx[0].data);
            end
            checks++;
            if (rx[1].pc !== 64'h104 || rx[1].data !== 32'h1000_0104) begin
                errors++;
                $display("[TB] FAIL redir_second actual=%h/%h expected=104/10000104", rx[1].pc, rx[1].data);
            end
            checks++;
            if (reqlog[2] !== 64'h100) begin
                errors++;
                $display("[TB] FAIL redir_req_addr actual=%h expected=100", reqlog[2]);
            end
        end
    endtask

    task automatic test_halt();
        int n;
        int k;
        hold_reset();
        lat = 1;
        ready_mode = 1;
        instr_ready = 1'b1;
        eop_addr = 64'h10;
        release_reset();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (halted === 1'b1) break;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt_reached actual=%0b expected=1", halted);
        end
        n = reqlog.size();
        repeat (5) @(negedge clk);
        #3;
        checks++;
        if (reqlog.size() !== n || req_valid !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt_no_requests actual=%0d reqs valid=%0b halted=%0b expected=%0d/0/1",
                     reqlog.size(), req_valid, halted, n);
        end
        checks++;
        if (rx.size() < 5) begin
            errors++;
            $display("[TB] FAIL halt_eop_delivered actual=%0d words expected>=5", rx.size());
        end else if (rx[4].pc !== 64'h10 || rx[4].data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL halt_eop_word actual=%h/%h expected=10/ffffffff", rx[4].pc, rx[4].data);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        k = rx.size();
        @(negedge clk);
        redirect = 1'b0;
        #3;
        checks++;
        if (halted !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h0) begin
            errors++;
            $display("[TB] FAIL halt_resume actual=%0b/%0b/%h expected=0/1/0", halted, req_valid, req_addr);
        end
        for (int i = 0; i < 30 && rx.size() <= k; i++) @(negedge clk);
        checks++;
        if (rx.size() <= k) begin
            errors++;
            $display("[TB] FAIL halt_resume_timeout actual=%0d words expected>%0d", rx.size(), k);
        end else if (rx[k].pc !== 64'h0 || rx[k].data !== 32'h1000_0000) begin
            errors++;
            $display("[TB] FAIL halt_resume_word actual=%h/%h expected=0/10000000", rx[k].pc, rx[k].data);
        end
    endtask

    task automatic test_random_ready();
        logic        prev_stall;
        logic [63:0] prev_addr;
        logic        bad;
        hold_reset();
        lat = 2;
        ready_mode = 2;
        instr_ready = 1'b1;
        prev_stall = 1'b0;
        prev_addr = '0;
        release_reset();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #3;
            if (prev_stall) begin
                checks++;
                if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
                    errors++;
                    $display("[TB] FAIL rand_addr_stable actual=%0b/%h expected=1/%h", req_valid, req_addr, prev_addr);
                end
            end
            prev_stall = req_valid && !req_ready;
            prev_addr  = req_addr;
        end
        checks++;
        if (reqlog.size() < 8 || rx.size() < 4) begin
            errors++;
            $display("[TB] FAIL rand_progress actual=%0d reqs/%0d words expected>=8/4", reqlog.size(), rx.size());
        end
        bad = 1'b0;
        for (int i = 0; i < reqlog.size(); i++) begin
            if (reqlog[i] !== 64'(i * 4)) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL rand_req_sequence actual=non-sequential expected=0,4,8,...");
        end
        bad = 1'b0;
        for (int i = 0; i < rx.size(); i++) begin
            if (rx[i].pc !== 64'(i * 4) || rx[i].data !== (32'h1000_0000 | 32'(i * 4))) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("[TB] FAIL rand_instr_sequence actual=non-sequential expected=pc 0,4,8,...");
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        int   n;
        int   k;
        hold_reset();
        lat = 2;
        ready_mode = 1;
        instr_ready = 1'b1;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #3;
            if (instr_valid && resp_valid && req_valid && req_ready) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL collide_setup actual=not found expected=pop+resp+req cycle");
        end else begin
            n = reqlog.size();
            k = rx.size();
            redirect    = 1'b1;
            redirect_pc = 64'h202;
            @(negedge clk);
            redirect = 1'b0;
            for (int i = 0; i < 40 && rx.size() < k + 2; i++) @(negedge clk);
            checks++;
            if (rx.size() < k + 2) begin
                errors++;
                $display("[TB] FAIL collide_timeout actual=%0d words expected=%0d", rx.size(), k + 2);
            end else begin
                checks++;
                if (rx[k].pc !== 64'h200 || rx[k].data !== 32'h1000_0200) begin
                    errors++;
                    $display("[TB] FAIL collide_first actual=%h/%h expected=200/10000200", rx[k].pc, rx[k].data);
                end
                checks++;
                if (rx[k+1].pc !== 64'h204 || rx[k+1].data !== 32'h1000_0204) begin
                    errors++;
                    $display("[TB] FAIL collide_second actual=%h/%h expected=204/10000204", rx[k+1].pc, rx[k+1].data);
                end
                checks++;
                if (reqlog[n+1] !== 64'h200) begin
                    errors++;
                    $display("[TB] FAIL collide_req_addr actual=%h expected=200", reqlog[n+1]);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_random_ready();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
